// File: rtl/clk_ctrl_pkg.sv
// Shared types and helpers for the alarm-clock sequencer.
// Holds the mode and alarm state encodings plus the counter width helper.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_T = 2'd1,
    SET_A = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RING = 2'd1,
    HOLD = 2'd2
  } alm_t;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/tick_pacer.sv
// Pulse rising-edge detector and mod-SET_DIV pacer for manual set stepping.
// tick is combinational on the detecting cycle; step is tick gated by pacer==0.
module tick_pacer
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned SET_DIV = 32'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  input  logic restart,
  output logic tick,
  output logic step
);

  localparam int unsigned PW = cnt_width(SET_DIV);
  localparam logic [PW-1:0] PACE_LAST = PW'(SET_DIV - 32'd1);

  logic          pulse_q;
  logic [PW-1:0] pace_q;
  logic [PW-1:0] pace_d;

  assign tick = pulse & ~pulse_q;
  assign step = tick & (pace_q == '0);

  // Pacer restarts on every mode change so the first tick in a set mode steps.
  always_comb begin
    pace_d = pace_q;
    if (restart) begin
      pace_d = '0;
    end else if (tick) begin
      if (pace_q == PACE_LAST) begin
        pace_d = '0;
      end else begin
        pace_d = pace_q + PW'(32'd1);
      end
    end else begin
      pace_d = pace_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q <= 1'b0;
      pace_q  <= '0;
    end else begin
      pulse_q <= pulse;
      pace_q  <= pace_d;
    end
  end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm-clock sequencer: mode FSM, alarm ring FSM and registered counter enables.
// Holds no time value; the datapath reports its counter limits and alarm match.
module alarm_clock_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned RING_TICKS = 32'd60,
  parameter int unsigned SET_DIV    = 32'd1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Pulse,
  input  logic Timeset,
  input  logic Alarmset,
  input  logic Minadv,
  input  logic Hrsadv,
  input  logic Dayadv,
  input  logic Alarmon,
  input  logic S_max,
  input  logic M_max,
  input  logic H_max,
  input  logic Alarm_eq,
  output logic Sec_inc,
  output logic Min_inc,
  output logic Hrs_inc,
  output logic Day_inc,
  output logic Amin_inc,
  output logic Ahrs_inc,
  output logic Sec_clr,
  output logic Disp_alm,
  output logic Buzz
);

  localparam int unsigned RW = cnt_width(RING_TICKS);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TICKS - 32'd1);

  mode_t         mode_q, mode_d;
  alm_t          alm_q, alm_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;

  logic tick_s, step_s, restart_s;
  logic run_tick_s, set_t_step_s, set_a_step_s;

  logic sec_inc_q, sec_inc_d, min_inc_q, min_inc_d;
  logic hrs_inc_q, hrs_inc_d, day_inc_q, day_inc_d;
  logic amin_inc_q, amin_inc_d, ahrs_inc_q, ahrs_inc_d;
  logic sec_clr_q, sec_clr_d, disp_alm_q, disp_alm_d;
  logic buzz_q, buzz_d;

  assign restart_s = (mode_d != mode_q);

  tick_pacer #(
    .SET_DIV (SET_DIV)
  ) u_pacer (
    .clk     (Clk),
    .rst     (Reset),
    .pulse   (Pulse),
    .restart (restart_s),
    .tick    (tick_s),
    .step    (step_s)
  );

  // Mode selection; Timeset always wins over Alarmset.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      RUN: begin
        if (Timeset) begin
          mode_d = SET_T;
        end else if (Alarmset) begin
          mode_d = SET_A;
        end else begin
          mode_d = RUN;
        end
      end
      SET_T: begin
        if (!Timeset) begin
          mode_d = RUN;
        end else begin
          mode_d = SET_T;
        end
      end
      SET_A: begin
        if (Timeset) begin
          mode_d = SET_T;
        end else if (!Alarmset) begin
          mode_d = RUN;
        end else begin
          mode_d = SET_A;
        end
      end
      default: mode_d = RUN;
    endcase
  end

  // Enables use the pre-change mode so a mode switch on a tick cycle is clean.
  assign run_tick_s   = tick_s & ((mode_q == RUN) | (mode_q == SET_A));
  assign set_t_step_s = step_s & (mode_q == SET_T);
  assign set_a_step_s = step_s & (mode_q == SET_A);

  always_comb begin
    sec_inc_d  = run_tick_s;
    min_inc_d  = (run_tick_s & S_max) | (set_t_step_s & Minadv);
    hrs_inc_d  = (run_tick_s & S_max & M_max) | (set_t_step_s & Hrsadv);
    day_inc_d  = (run_tick_s & S_max & M_max & H_max) | (set_t_step_s & Dayadv);
    amin_inc_d = set_a_step_s & Minadv;
    ahrs_inc_d = set_a_step_s & Hrsadv;
    sec_clr_d  = (mode_d == SET_T) & (mode_q != SET_T);
    disp_alm_d = (mode_d == SET_A);
  end

  // Ring FSM: Alarmon and mode exits act every clock, everything else on ticks.
  always_comb begin
    alm_d      = alm_q;
    ring_cnt_d = ring_cnt_q;
    case (alm_q)
      IDLE: begin
        if (tick_s && (mode_q == RUN) && (mode_d == RUN) && Alarmon && Alarm_eq) begin
          alm_d      = RING;
          ring_cnt_d = '0;
        end else begin
          alm_d = IDLE;
        end
      end
      RING: begin
        if ((mode_d != RUN) || !Alarmon) begin
          alm_d = IDLE;
        end else if (tick_s) begin
          if (ring_cnt_q == RING_LAST) begin
            alm_d = HOLD;
          end else begin
            ring_cnt_d = ring_cnt_q + RW'(32'd1);
          end
        end else begin
          alm_d = RING;
        end
      end
      HOLD: begin
        // Stay silent until the matching minute has passed.
        if (mode_d != RUN) begin
          alm_d = IDLE;
        end else if (tick_s && !Alarm_eq) begin
          alm_d = IDLE;
        end else begin
          alm_d = HOLD;
        end
      end
      default: alm_d = IDLE;
    endcase
    buzz_d = (alm_d == RING);
  end

  // FSM state registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mode_q     <= RUN;
      alm_q      <= IDLE;
      ring_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      alm_q      <= alm_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sec_inc_q  <= 1'b0;
      min_inc_q  <= 1'b0;
      hrs_inc_q  <= 1'b0;
      day_inc_q  <= 1'b0;
      amin_inc_q <= 1'b0;
      ahrs_inc_q <= 1'b0;
      sec_clr_q  <= 1'b0;
      disp_alm_q <= 1'b0;
      buzz_q     <= 1'b0;
    end else begin
      sec_inc_q  <= sec_inc_d;
      min_inc_q  <= min_inc_d;
      hrs_inc_q  <= hrs_inc_d;
      day_inc_q  <= day_inc_d;
      amin_inc_q <= amin_inc_d;
      ahrs_inc_q <= ahrs_inc_d;
      sec_clr_q  <= sec_clr_d;
      disp_alm_q <= disp_alm_d;
      buzz_q     <= buzz_d;
    end
  end

  assign Sec_inc  = sec_inc_q;
  assign Min_inc  = min_inc_q;
  assign Hrs_inc  = hrs_inc_q;
  assign Day_inc  = day_inc_q;
  assign Amin_inc = amin_inc_q;
  assign Ahrs_inc = ahrs_inc_q;
  assign Sec_clr  = sec_clr_q;
  assign Disp_alm = disp_alm_q;
  assign Buzz     = buzz_q;

endmodule
